logic_unit_iter: RTL and testbench
==================================

// Module: logic_unit_iter
// PURPOSE
//  Area-reduced, multi-cycle 64-bit bitwise logic unit (XOR/OR/AND/XNOR) for the RV64 integer path.
//  Processes one SLICE-wide chunk per cycle, LSB chunk first.
//  Valid/ready handshakes on both sides. Drop-in sequential counterpart of the combinational xor64b.
// PARAMETERS
//  XLEN   64  operand/result width
//  SLICE  16  bits processed per cycle; XLEN % SLICE == 0 is required (elaboration-time $error otherwise)
// PORTS
//  clk        in   1     single clock, all state on rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  in_valid   in   1     request valid
//  in_ready   out  1     unit can accept a request
//  a          in   XLEN  operand A, sampled on input handshake
//  b          in   XLEN  operand B, sampled on input handshake
//  op         in   2     logic_op_t: 00 XOR, 01 OR, 10 AND, 11 XNOR
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer accepts result
//  s          out  XLEN  result
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - state=IDLE, cnt=0, s=0, out_valid=0, in_ready=1 (combinational from IDLE).
//   - Internal a/b/op registers cleared to 0.
//  Assertion mid-operation aborts the request. No result is emitted for it.
//  FSM states: IDLE, BUSY, DONE
//  IDLE
//   - in_ready=1.
//   - On in_valid: latch a, b, op; clear s to 0; cnt=0; go to BUSY.
//  BUSY
//   - in_ready=0, out_valid=0.
//   - Each cycle: s[cnt*SLICE +: SLICE] = f(op, a_q slice, b_q slice); cnt++.
//   - When cnt==NSLICE-1 (NSLICE = XLEN/SLICE), the write still occurs, then go to DONE.
//   - cnt width: $clog2(NSLICE), min 1. It wraps to 0 on entry to DONE.
//  DONE
//   - out_valid=1; s holds the full result, stable until the handshake.
//   - On out_ready: go to IDLE next cycle.
//   - out_valid may stall indefinitely. a/b/op changes on the inputs are ignored.
//  Latency
//   - Handshake at edge N gives out_valid=1 after edge N+NSLICE (4 with defaults).
//   - Throughput: one op per NSLICE+2 cycles.
//  Boundary cases
//   - in_ready is low in BUSY/DONE: no accept, even if in_valid and out_ready coincide.
//   - out_ready while not DONE is ignored.
//   - SLICE==XLEN is legal: BUSY lasts one cycle.
//   - Inputs X/Z outside a handshake must not corrupt state.
//  Arithmetic
//   - Pure bitwise, no carries; result width exactly XLEN.
//   - Result equals a op b for all operand values.
// STRUCTURE
//  Package rv_logic_pkg
//   - typedef enum logic [1:0] logic_op_t {LOP_XOR, LOP_OR, LOP_AND, LOP_XNOR}
//   - typedef enum logic [1:0] liu_state_t {IDLE, BUSY, DONE}
//  Sub-module logic_slice #(W)
//   - Combinational f(op, a, b) on W bits; instantiated once with W=SLICE.
//  The top holds the FSM, counter and registers.
// TESTING (self-check vs a op b, error counter, summary $display)
//  1 Reset
//    - rst_n=0 then released -> out_valid=0, in_ready=1, s=0.
//  2 Single XOR
//    - a=64'hFFFF_0000_AAAA_5555, b=64'h0F0F_0F0F_0F0F_0F0F, op=XOR.
//    - out_valid rises exactly 4 cycles after the handshake; s=64'hF0F0_0F0F_A5A5_5A5A.
//  3 All ops
//    - a=64'hDEAD_BEEF_0123_4567, b=64'hFFFF_0000_FFFF_0000.
//    - OR  -> 64'hFFFF_BEEF_FFFF_4567
//    - AND -> 64'hDEAD_0000_0123_0000
//    - XNOR -> 64'hDEAD_4110_0123_BA98
//  4 Backpressure
//    - out_ready=0 for 10 cycles in DONE -> s stable, in_ready=0.
//    - A new in_valid is not accepted until the cycle after out_ready=1.
//  5 Reset mid-op
//    - Drop rst_n at cnt=2 -> immediately s=0, out_valid=0.
//    - After release, a new op completes correctly.
//  6 Random
//    - 1000 ops with {$urandom,$urandom} operands and random op.
//    - Random in_valid/out_ready gaps; 0 errors required.

Source files
------------

// File: rtl/rv_logic_pkg.sv
// Shared types for the iterative RV64 bitwise logic unit.
package rv_logic_pkg;

   typedef enum logic [1:0] {
      LOP_XOR  = 2'b00,
      LOP_OR   = 2'b01,
      LOP_AND  = 2'b10,
      LOP_XNOR = 2'b11
   } logic_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } liu_state_t;

endpackage : rv_logic_pkg

// File: rtl/logic_slice.sv
// Combinational bitwise function f(op, a, b) on a W-bit slice.
module logic_slice
   import rv_logic_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic [1:0]   i_op,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_y_c
);

   logic_op_t w_op;

   assign w_op = logic_op_t'(i_op);

   always_comb begin
      o_y_c = '0;
      unique case (w_op)
         LOP_XOR:  o_y_c = i_a ^ i_b;
         LOP_OR:   o_y_c = i_a | i_b;
         LOP_AND:  o_y_c = i_a & i_b;
         LOP_XNOR: o_y_c = ~(i_a ^ i_b);
      endcase
   end

endmodule : logic_slice

// File: rtl/logic_unit_iter.sv
// Multi-cycle bitwise logic unit: one SLICE-wide chunk per cycle, LSB chunk first,
// with valid/ready handshakes on request and result sides.
module logic_unit_iter
   import rv_logic_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned SLICE = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [1:0]      op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] s
);

   localparam int unsigned NSLICE = XLEN / SLICE;
   localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

   generate
      if ((XLEN % SLICE) != 0) begin : g_bad_slice
         $error("logic_unit_iter: XLEN must be a multiple of SLICE");
      end
   endgenerate

   liu_state_t       r_state;
   liu_state_t       w_state_nxt;
   logic             w_accept;
   logic             w_step;
   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0]  r_a;
   logic [XLEN-1:0]  r_b;
   logic_op_t        r_op;
   logic [XLEN-1:0]  r_s;
   logic [31:0]      w_shamt;
   logic [SLICE-1:0] w_a_sl;
   logic [SLICE-1:0] w_b_sl;
   logic [SLICE-1:0] w_y_sl;
   logic [XLEN-1:0]  w_slot_mask;
   logic [XLEN-1:0]  w_s_nxt;

   // Current chunk selected by bit offset cnt*SLICE.
   assign w_shamt     = 32'(r_cnt) * 32'(SLICE);
   assign w_a_sl      = SLICE'(r_a >> w_shamt);
   assign w_b_sl      = SLICE'(r_b >> w_shamt);
   assign w_slot_mask = XLEN'({SLICE{1'b1}}) << w_shamt;
   assign w_s_nxt     = (r_s & ~w_slot_mask) | (XLEN'(w_y_sl) << w_shamt);

   logic_slice #(
      .W (SLICE)
   ) u_slice (
      .i_op  (r_op),
      .i_a   (w_a_sl),
      .i_b   (w_b_sl),
      .o_y_c (w_y_sl)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            w_step = 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operands are only sampled on the accept strobe, so input noise elsewhere is harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_op  <= LOP_XOR;
         r_s   <= '0;
      end else if (w_accept) begin
         r_cnt <= '0;
         r_a   <= a;
         r_b   <= b;
         r_op  <= logic_op_t'(op);
         r_s   <= '0;
      end else if (w_step) begin
         r_s   <= w_s_nxt;
         r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign s         = r_s;

endmodule : logic_unit_iter

// File: tb/tb_logic_unit_iter.sv
// Randomized self-checking bench for logic_unit_iter against a plain bitwise reference.
module tb_logic_unit_iter;

   localparam int NSLICE = 4;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic [1:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] s;

   int n_checks;
   int n_errors;

   logic_unit_iter #(
      .XLEN  (64),
      .SLICE (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_f(input logic [1:0] fop, input logic [63:0] fa,
                                         input logic [63:0] fb);
      case (fop)
         2'd0:    return fa ^ fb;
         2'd1:    return fa | fb;
         2'd2:    return fa & fb;
         default: return ~(fa ^ fb);
      endcase
   endfunction

   // One request/response transaction; hold = cycles of result backpressure.
   task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_in, input logic [1:0] top,
                         input logic [63:0] exp, input int gap, input int hold, input bit noisy);
      int lat;
      repeat (gap) begin
         @(negedge clk);
         a  = {$urandom, $urandom};
         b  = {$urandom, $urandom};
         op = 2'($urandom);
      end
      @(negedge clk);
      check("in_ready_idle", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      a        = ta;
      b        = tb_in;
      op       = top;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = {$urandom, $urandom};
      b        = {$urandom, $urandom};
      op       = 2'($urandom);
      lat      = 0;
      while (lat < 64) begin
         @(negedge clk);
         if (out_valid) break;
         if (lat == 0) check("in_ready_busy", 64'(in_ready), 64'd0);
         if (noisy) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
         end
         lat++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("latency", 64'(lat), 64'(NSLICE));
      check("result", s, exp);
      repeat (hold) begin
         @(negedge clk);
         in_valid = 1'($urandom);
         a        = {$urandom, $urandom};
         check("hold_s", s, exp);
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_out_valid", 64'(out_valid), 64'd1);
      end
      // in_valid together with out_ready must not be accepted in DONE.
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check("post_ack_in_ready", 64'(in_ready), 64'd1);
      check("post_ack_out_valid", 64'(out_valid), 64'd0);
      check("post_ack_s_kept", s, exp);
   endtask

   initial begin
      logic [63:0] ra;
      logic [63:0] rb;
      logic [1:0]  rop;
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      op        = '0;

      // Reset
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_s", s, 64'd0);

      // Directed patterns
      run_op(64'hFFFF_0000_AAAA_5555, 64'h0F0F_0F0F_0F0F_0F0F, 2'd0,
             64'hF0F0_0F0F_A5A5_5A5A, 0, 0, 1'b0);
      run_op(64'hDEAD_BEEF_0123_4567, 64'hFFFF_0000_FFFF_0000, 2'd1,
             64'hFFFF_BEEF_FFFF_4567, 0, 0, 1'b0);
      run_op(64'hDEAD_BEEF_0123_4567, 64'hFFFF_0000_FFFF_0000, 2'd2,
             64'hDEAD_0000_0123_0000, 1, 0, 1'b0);
      run_op(64'hDEAD_BEEF_0123_4567, 64'hFFFF_0000_FFFF_0000, 2'd3,
             64'hDEAD_4110_0123_BA98, 0, 0, 1'b0);

      // Backpressure for 10 cycles with noisy in_valid
      run_op(64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 2'd0,
             64'hEDCB_A987_9ABC_DEF0, 0, 10, 1'b1);

      // Reset in the middle of an operation (cnt==2)
      @(negedge clk);
      in_valid = 1'b1;
      a        = 64'hFFFF_FFFF_FFFF_FFFF;
      b        = 64'h0;
      op       = 2'd1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_s", s, 64'd0);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("midrst_no_result", 64'(out_valid), 64'd0);
      end
      run_op(64'hA5A5_A5A5_5A5A_5A5A, 64'hFFFF_0000_FFFF_0000, 2'd3,
             64'hA5A5_5A5A_5A5A_A5A5, 0, 0, 1'b0);

      // Random operations with random gaps and backpressure
      for (int i = 0; i < 1000; i++) begin
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         rop = 2'($urandom);
         run_op(ra, rb, rop, ref_f(rop, ra, rb), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_logic_unit_iter
